vga_sprite_scanner: RTL and testbench
=====================================

// Module: vga_sprite_scanner
// PURPOSE
//   Display-side counterpart of the sprite icon readers: generates the raster scan
//   (pixel_row / pixel_column) that icon blocks consume, waits out their RAM read latency,
//   then samples the returned 12-bit icon and composites it over a background colour.
//   Drives VGA hsync / vsync / rgb. Icon value TRANSPARENT (12'h000) shows the background.
// PARAMETERS
//   PIX_DIV      4        clk cycles per pixel (100 MHz clk -> 25 MHz pixel)
//   ICON_LATENCY 2        clk cycles from a coordinate change to a valid icon; must be < PIX_DIV
//   H_ACTIVE     640      visible columns
//   H_FP         16       horizontal front porch, in pixels
//   H_SYNC       96       hsync width, in pixels
//   H_BP         48       horizontal back porch, in pixels
//   V_ACTIVE     480      visible rows
//   V_FP         10       vertical front porch, in lines
//   V_SYNC       2        vsync width, in lines
//   V_BP         33       vertical back porch, in lines
//   TRANSPARENT  12'h000  icon code meaning "no sprite pixel"
// PORTS
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-low reset
//   pixel_row     out  32  signed; current scan line, v_cnt zero-extended
//   pixel_column  out  32  signed; current scan column, h_cnt zero-extended
//   video_on      out  1   high when the current coordinate is inside the active area
//   icon          in   12  sprite colour for the current coordinate, valid ICON_LATENCY clks after it changes
//   background    in   12  background colour for the current coordinate
//   vga_hsync     out  1   active-low horizontal sync
//   vga_vsync     out  1   active-low vertical sync
//   vga_rgb       out  12  {R[3:0],G[3:0],B[3:0]}
//   frame_start   out  1   one-clk pulse; the next pixel is (0,0)
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//   - Elaboration fails (generate $error) if ICON_LATENCY >= PIX_DIV.
//   - pix_cnt counts 0..PIX_DIV-1 and wraps. pix_tick = (pix_cnt == PIX_DIV-1).
//   - On pix_tick, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
//     At V_TOTAL-1, v_cnt wraps to 0.
//   - pixel_row, pixel_column and video_on are registered copies of v_cnt/h_cnt.
//     They hold for PIX_DIV clks and are driven during blanking too.
//   - Sampling happens on pix_tick (the last clk of the pixel period), after
//     ICON_LATENCY <= PIX_DIV-1 clks. On that edge:
//       vga_rgb   <= !video_on ? 12'h000 : (icon != TRANSPARENT ? icon : background)
//       vga_hsync <= !(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
//       vga_vsync <= !(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
//     So rgb and syncs trail the coordinates by exactly one pixel period and stay aligned
//     with each other. Between ticks, all three outputs hold.
//   - frame_start = 1 for the single clk where pix_tick && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
//   - Reset (reset==0 at a clk edge): pix_cnt, h_cnt, v_cnt, pixel_row, pixel_column <= 0;
//     video_on <= 0; vga_rgb <= 12'h000; vga_hsync, vga_vsync <= 1; frame_start <= 0.
//   - Reset asserted mid-frame aborts the frame. The first clk after release shows
//     coordinate (0,0), and the first pix_tick comes PIX_DIV clks after release.
//   - icon and background are sampled only on pix_tick. Changes at other times
//     (icon RAM settling) never reach vga_rgb.
//   - Simultaneous wraps (end of line on the last line) are handled in the same
//     pix_tick: h_cnt->0, v_cnt->0, frame_start pulses.
// TESTING
//   1 Reset low 3 clks, then release -> hsync=vsync=1, rgb=0, row=col=0;
//     col becomes 1 exactly 4 clks after release.
//   2 Free-run one frame -> exactly 800*525*4 = 1,680,000 clks between frame_start pulses;
//     hsync low for 96*4 = 384 clks starting at col 656; vsync low for lines 490-491.
//   3 icon model with 2-clk latency returns 12'hF00 at col 100, row 50, else 12'h000;
//     background 12'h00F -> rgb=F00 for exactly one pixel period, starting one pixel
//     period after col 100 is driven; all other active pixels = 00F.
//   4 icon=12'hFFF and background=12'h0F0 held during blanking (col 700) -> rgb=000.
//   5 icon toggles 12'h123/12'h000 every clk inside a pixel period, settling to 12'h456
//     before the tick -> rgb=456.
//   6 Reset pulsed at row 300, col 400 -> after release, row=col=0 and the next
//     frame_start comes 1,680,000 - 4 clks later; no sync glitch during reset.

Source files
------------

// File: rtl/vga_sprite_scanner.sv
// vga_sprite_scanner: VGA raster generator and icon/background compositor.
// Drives the scan coordinates that the icon readers consume. Each pixel period lasts
// PIX_DIV clks, and the returned icon is sampled on the last clk of that period.
// The composited colour and the syncs are emitted one pixel period behind the coordinates.
`timescale 1ns/1ps
module vga_sprite_scanner #(
    parameter int          PIX_DIV      = 4,
    parameter int          ICON_LATENCY = 2,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [11:0] TRANSPARENT  = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    output logic signed [31:0] pixel_row,
    output logic signed [31:0] pixel_column,
    output logic               video_on,
    input  logic [11:0]        icon,
    input  logic [11:0]        background,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [11:0]        vga_rgb,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    // The icon must have settled before the sampling clk of the same pixel period.
    generate
        if (ICON_LATENCY >= PIX_DIV) begin : g_bad_latency
            $error("vga_sprite_scanner: ICON_LATENCY must be smaller than PIX_DIV");
        end
    endgenerate

    // Coordinate is inside the visible window.
    function automatic logic in_active(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (32'(h) < 32'(H_ACTIVE)) && (32'(v) < 32'(V_ACTIVE));
    endfunction

    // Active-low sync level for a counter value and its sync window.
    function automatic logic sync_level(input logic [31:0] cnt, input logic [31:0] start,
                                        input logic [31:0] width);
        return !((cnt >= start) && (cnt < start + width));
    endfunction

    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   pixel_row_q, pixel_row_d;
    logic [31:0]   pixel_column_q, pixel_column_d;
    logic          video_on_q, video_on_d;
    logic [11:0]   vga_rgb_q, vga_rgb_d;
    logic          vga_hsync_q, vga_hsync_d;
    logic          vga_vsync_q, vga_vsync_d;
    logic          frame_start_q, frame_start_d;
    logic          pix_tick_s;

    assign pix_tick_s = (pix_cnt_q == PIX_LAST);

    // Next raster position: pixel divider, then column, then line, wrapping together.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_tick_s) begin
            pix_cnt_d = {PW{1'b0}};
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = {HW{1'b0}};
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = {VW{1'b0}};
                end else begin
                    v_cnt_d = v_cnt_q + VW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
        end
    end

    // Outputs: coordinates track the counters; colour and syncs update only on the tick.
    always_comb begin
        pixel_row_d    = 32'(v_cnt_d);
        pixel_column_d = 32'(h_cnt_d);
        video_on_d     = in_active(h_cnt_d, v_cnt_d);
        // High for the clk whose following edge is the last tick of the frame.
        frame_start_d  = (pix_cnt_d == PIX_LAST) && (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
        vga_rgb_d      = vga_rgb_q;
        vga_hsync_d    = vga_hsync_q;
        vga_vsync_d    = vga_vsync_q;
        if (pix_tick_s) begin
            if (!video_on_q) begin
                vga_rgb_d = 12'h000;
            end else if (icon != TRANSPARENT) begin
                vga_rgb_d = icon;
            end else begin
                vga_rgb_d = background;
            end
            vga_hsync_d = sync_level(32'(h_cnt_q), 32'(H_ACTIVE + H_FP), 32'(H_SYNC));
            vga_vsync_d = sync_level(32'(v_cnt_q), 32'(V_ACTIVE + V_FP), 32'(V_SYNC));
        end else begin
            vga_rgb_d   = vga_rgb_q;
            vga_hsync_d = vga_hsync_q;
            vga_vsync_d = vga_vsync_q;
        end
    end

    // State and output registers; reset aborts the frame and parks syncs inactive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_cnt_q      <= {PW{1'b0}};
            h_cnt_q        <= {HW{1'b0}};
            v_cnt_q        <= {VW{1'b0}};
            pixel_row_q    <= 32'd0;
            pixel_column_q <= 32'd0;
            video_on_q     <= 1'b0;
            vga_rgb_q      <= 12'h000;
            vga_hsync_q    <= 1'b1;
            vga_vsync_q    <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            pix_cnt_q      <= pix_cnt_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            pixel_row_q    <= pixel_row_d;
            pixel_column_q <= pixel_column_d;
            video_on_q     <= video_on_d;
            vga_rgb_q      <= vga_rgb_d;
            vga_hsync_q    <= vga_hsync_d;
            vga_vsync_q    <= vga_vsync_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign pixel_row    = pixel_row_q;
    assign pixel_column = pixel_column_q;
    assign video_on     = video_on_q;
    assign vga_rgb      = vga_rgb_q;
    assign vga_hsync    = vga_hsync_q;
    assign vga_vsync    = vga_vsync_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_sprite_scanner.sv
// tb_vga_sprite_scanner: directed + randomized bench for vga_sprite_scanner.
// Uses a scaled-down raster so whole frames fit in a short run. A reference model
// derives every expected output from the number of clks since reset, using plain
// division and modulo over the frame geometry.
`timescale 1ns/1ps
module tb_vga_sprite_scanner;

    localparam int PD  = 4;
    localparam int LAT = 2;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * PD;
    localparam int SC = 5, SR = 3;
    localparam int M_RAND = 0, M_SPRITE = 1, M_BLANK = 2, M_TOGGLE = 3;

    logic               clk;
    logic               reset;
    logic signed [31:0] pixel_row, pixel_column;
    logic               video_on;
    logic [11:0]        icon, background;
    logic               vga_hsync, vga_vsync;
    logic [11:0]        vga_rgb;
    logic               frame_start;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: clks elapsed in the current frame and the latched output values.
    int          n = 0;
    bit          m_rst = 1'b1;
    logic [11:0] e_rgb = 12'h000;
    logic        e_hs = 1'b1;
    logic        e_vs = 1'b1;
    int          mode = M_RAND;

    vga_sprite_scanner #(
        .PIX_DIV(PD), .ICON_LATENCY(LAT),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .TRANSPARENT(12'h000)
    ) dut (
        .clk(clk), .reset(reset),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .video_on(video_on),
        .icon(icon), .background(background),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk: advance the model at the edge, drive the next inputs, compare at negedge.
    task automatic step();
        int k, col, row, age;
        @(posedge clk);
        if (!reset) begin
            n = 0; m_rst = 1'b1; e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            if (n % PD == PD - 1) begin
                k = n / PD; col = k % HT; row = k / HT;
                if (col < HA && row < VA)
                    e_rgb = (icon != 12'h000) ? icon : background;
                else
                    e_rgb = 12'h000;
                e_hs = !(col >= HA + HF && col < HA + HF + HS);
                e_vs = !(row >= VA + VF && row < VA + VF + VS);
            end
            n = (n + 1) % FRAME;
            m_rst = 1'b0;
        end
        k = n / PD; col = k % HT; row = k / HT; age = n % PD;
        #1;
        case (mode)
            M_SPRITE: begin
                background = 12'h00F;
                if (age < LAT) icon = 12'($urandom);
                else icon = (col == SC && row == SR) ? 12'hF00 : 12'h000;
            end
            M_BLANK: begin
                icon = 12'hFFF; background = 12'h0F0;
            end
            M_TOGGLE: begin
                background = 12'h0AA;
                if (age == PD - 1) icon = 12'h456;
                else icon = (age % 2 == 0) ? 12'h123 : 12'h000;
            end
            default: begin
                icon = 12'($urandom); background = 12'($urandom);
            end
        endcase
        @(negedge clk);
        chk("col", pixel_column, col);
        chk("row", pixel_row, row);
        chk("video_on", 32'(video_on), (!m_rst && col < HA && row < VA) ? 1 : 0);
        chk("rgb", 32'(vga_rgb), 32'(e_rgb));
        chk("hsync", 32'(vga_hsync), 32'(e_hs));
        chk("vsync", 32'(vga_vsync), 32'(e_vs));
        chk("frame_start", 32'(frame_start), (!m_rst && n == FRAME - 1) ? 1 : 0);
    endtask

    initial begin
        int cnt, hs_low, vs_low, fall_col, red, blue, first_col, first_row, cnt456, cnt123, white;
        bit prev_hs;
        reset = 1'b0; icon = 12'h000; background = 12'h000;

        // 1: reset for 3 clks, then the first column step comes PD clks after release
        repeat (3) step();
        chk("rst_hsync", 32'(vga_hsync), 1);
        chk("rst_vsync", 32'(vga_vsync), 1);
        chk("rst_rgb", 32'(vga_rgb), 0);
        chk("rst_fs", 32'(frame_start), 0);
        reset = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (pixel_column != 1 && cnt < 20);
        chk("col1_latency", cnt, PD);

        // 2: free-running frame period and sync pulse geometry
        cnt = 0;
        do begin step(); cnt++; end while (!frame_start && cnt < 2 * FRAME);
        chk("fs_seen", 32'(frame_start), 1);
        cnt = 0; hs_low = 0; vs_low = 0; fall_col = -1; prev_hs = 1'b1;
        do begin
            step(); cnt++;
            if (!vga_hsync) hs_low++;
            if (!vga_vsync) vs_low++;
            if (prev_hs && !vga_hsync && fall_col < 0) fall_col = pixel_column;
            prev_hs = vga_hsync;
        end while (!frame_start && cnt < 2 * FRAME);
        chk("frame_period", cnt, FRAME);
        chk("hsync_low_clks", hs_low, HS * PD * VT);
        chk("vsync_low_clks", vs_low, VS * HT * PD);
        chk("hsync_fall_col", fall_col, HA + HF + 1);

        // 3: single sprite pixel over a blue background
        mode = M_SPRITE;
        repeat (FRAME) step();
        red = 0; blue = 0; first_col = -1; first_row = -1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (vga_rgb == 12'hF00) begin
                if (red == 0) begin first_col = pixel_column; first_row = pixel_row; end
                red++;
            end
            if (vga_rgb == 12'h00F) blue++;
        end
        chk("sprite_clks", red, PD);
        chk("sprite_col", first_col, SC + 1);
        chk("sprite_row", first_row, SR);
        chk("bg_clks", blue, (HA * VA - 1) * PD);

        // 4: bright icon and background never show during blanking
        mode = M_BLANK;
        repeat (FRAME) step();
        white = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (pixel_column == HA + 2 && pixel_row == 0) chk("blank_rgb", 32'(vga_rgb), 0);
            if (vga_rgb == 12'hFFF) white++;
        end
        chk("white_clks", white, HA * VA * PD);

        // 5: icon churning inside the pixel period; only the settled value is shown
        mode = M_TOGGLE;
        repeat (FRAME) step();
        cnt456 = 0; cnt123 = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (vga_rgb == 12'h456) cnt456++;
            if (vga_rgb == 12'h123) cnt123++;
        end
        chk("settled_clks", cnt456, HA * VA * PD);
        chk("glitch_clks", cnt123, 0);

        // 6: reset mid-frame during the sync pulses, then a full frame from (0,0)
        mode = M_RAND;
        cnt = 0;
        do begin step(); cnt++; end
        while (!(pixel_row == VA + VF && pixel_column == HA + HF + 2) && cnt < 2 * FRAME);
        chk("mid_reached", pixel_column, HA + HF + 2);
        reset = 1'b0;
        repeat (2) begin
            step();
            chk("mid_rst_hsync", 32'(vga_hsync), 1);
            chk("mid_rst_vsync", 32'(vga_vsync), 1);
        end
        reset = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (pixel_column != 1 && cnt < 20);
        chk("mid_col1_latency", cnt, PD);
        // From the first column step (PD clks after release) to the frame wrap is FRAME-PD clks.
        cnt = 0;
        do begin step(); cnt++; end while (!frame_start && cnt < 2 * FRAME);
        step(); cnt++;
        chk("mid_wrap_col", pixel_column, 0);
        chk("mid_wrap_row", pixel_row, 0);
        chk("mid_frame_len", cnt, FRAME - PD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
